// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit timing engine:
//     - phase_t    : frame phase encoding (also the FSM state encoding and
//                    the value presented on o_phase)
//     - DIV_MIN    : smallest usable baud divisor
//     - data-bit encoding table 0..3 -> 5..8 and helpers built on it
package uart_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_START  = 3'd1,
    PH_DATA   = 3'd2,
    PH_PARITY = 3'd3,
    PH_STOP   = 3'd4
  } phase_t;

  // A divisor of 0 or 1 would make div-1 underflow or give a zero-length bit.
  localparam int DIV_MIN = 2;

  // Data-bit count indexed by the 2-bit i_data_bits encoding.
  localparam logic [3:0] DATA_BITS_TABLE [4] = '{4'd5, 4'd6, 4'd7, 4'd8};

  function automatic logic [3:0] data_bits_count(input logic [1:0] enc);
    return DATA_BITS_TABLE[enc];
  endfunction

  // Index of the final data bit (nbits-1), the point at which DATA ends.
  function automatic logic [2:0] last_data_idx(input logic [1:0] enc);
    logic [3:0] n;
    n = data_bits_count(enc) - 4'd1;
    return n[2:0];
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter
//   Bit-period counter for the UART TX timing engine. Counts 0..div-1 while
//   enabled and wraps, producing a strobe on the first and last clock of
//   every bit period.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   en          in   count enable (frame in progress)
//   clr         in   synchronous clear; holds the count at 0
//   div         in   DIV_W  clocks per bit (caller guarantees div >= 2)
//   end_of_bit  out  high on the cycle where count == div-1
//   bit_start   out  high on the cycle where count == 0
module uart_baud_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             end_of_bit,
  output logic             bit_start
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_last;

  assign count_last = div - DIV_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      // Wrap on the last clock of the bit so the next bit starts at 0.
      if (count_q == count_last) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + DIV_W'(1);
      end
    end
  end

  assign end_of_bit = en && !clr && (count_q == count_last);
  assign bit_start  = en && !clr && (count_q == '0);

endmodule

// File: rtl/uart_tx_frame_timer.sv
// uart_tx_frame_timer
//   UART transmit timing engine. Latches the frame configuration when a frame
//   is accepted, times each bit with a programmable divisor and sequences
//   START, DATA (5..8 bits, LSB first), optional PARITY and 1 or 2 STOP bits.
//   Tells the serialiser which bit to drive and tells the TX FIFO when to pop.
//   Back-to-back frames follow with no idle gap while i_start stays high.
//
// Parameters
//   DIV_W      width of the divisor and bit counter
//   DIV_RESET  divisor substituted when i_div is below DIV_MIN
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   i_div         in   DIV_W clocks per bit, sampled at frame acceptance
//   i_data_bits   in   2  data bit count 0..3 -> 5..8, sampled at acceptance
//   i_parity_en   in   1  insert a parity bit, sampled at acceptance
//   i_stop2       in   1  two stop bits when set, sampled at acceptance
//   i_start       in   1  level request (FIFO non-empty and TX enabled)
//   o_busy        out  1  frame in progress
//   o_bit_start   out  1  pulse on the first clock of every bit
//   o_phase       out  3  IDLE=0 START=1 DATA=2 PARITY=3 STOP=4
//   o_bit_idx     out  3  data bit index in DATA, stop index in STOP, else 0
//   o_fifo_pop    out  1  pulse on the first clock of START
//   o_frame_done  out  1  pulse on the last clock of the final stop bit
module uart_tx_frame_timer
  import uart_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 10416
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] i_div,
  input  logic [1:0]       i_data_bits,
  input  logic             i_parity_en,
  input  logic             i_stop2,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_bit_start,
  output logic [2:0]       o_phase,
  output logic [2:0]       o_bit_idx,
  output logic             o_fifo_pop,
  output logic             o_frame_done
);

  phase_t           phase_q;
  logic [2:0]       bit_idx_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       data_bits_q;
  logic             parity_q;
  logic             stop2_q;

  logic             end_of_bit;
  logic             bit_start;
  logic             in_frame;
  logic             last_stop;
  logic             frame_end;
  logic             accept;
  logic [DIV_W-1:0] div_eff;

  // Divisors too small to time a bit fall back to the safe default.
  assign div_eff = (i_div >= DIV_W'(DIV_MIN)) ? i_div : DIV_W'(DIV_RESET);

  assign in_frame  = (phase_q != PH_IDLE);
  assign last_stop = (bit_idx_q == 3'd1) || !stop2_q;
  assign frame_end = (phase_q == PH_STOP) && end_of_bit && last_stop;

  // A frame is accepted from IDLE or straight out of the final stop bit, so
  // consecutive frames run without an idle cycle.
  assign accept = i_start && ((phase_q == PH_IDLE) || frame_end);

  uart_baud_counter #(
    .DIV_W (DIV_W)
  ) u_baud_counter (
    .clk        (clk),
    .reset      (reset),
    .en         (in_frame),
    .clr        (!in_frame),
    .div        (div_q),
    .end_of_bit (end_of_bit),
    .bit_start  (bit_start)
  );

  // Configuration is captured only at acceptance; later input changes wait
  // for the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= DIV_W'(DIV_RESET);
      data_bits_q <= 2'd3;
      parity_q    <= 1'b0;
      stop2_q     <= 1'b0;
    end else if (accept) begin
      div_q       <= div_eff;
      data_bits_q <= i_data_bits;
      parity_q    <= i_parity_en;
      stop2_q     <= i_stop2;
    end
  end

  // Frame sequencer: advances one bit on every end-of-bit strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= PH_IDLE;
      bit_idx_q <= 3'd0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (i_start) begin
            phase_q   <= PH_START;
            bit_idx_q <= 3'd0;
          end
        end
        PH_START: begin
          if (end_of_bit) begin
            phase_q   <= PH_DATA;
            bit_idx_q <= 3'd0;
          end
        end
        PH_DATA: begin
          if (end_of_bit) begin
            if (bit_idx_q == last_data_idx(data_bits_q)) begin
              phase_q   <= parity_q ? PH_PARITY : PH_STOP;
              bit_idx_q <= 3'd0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        PH_PARITY: begin
          if (end_of_bit) begin
            phase_q   <= PH_STOP;
            bit_idx_q <= 3'd0;
          end
        end
        PH_STOP: begin
          if (end_of_bit) begin
            if (!last_stop) begin
              bit_idx_q <= 3'd1;
            end else begin
              bit_idx_q <= 3'd0;
              phase_q   <= i_start ? PH_START : PH_IDLE;
            end
          end
        end
        default: begin
          phase_q   <= PH_IDLE;
          bit_idx_q <= 3'd0;
        end
      endcase
    end
  end

  // Every output decodes registered state only; inputs never reach them
  // combinationally.
  assign o_busy       = in_frame;
  assign o_bit_start  = bit_start;
  assign o_phase      = phase_q;
  assign o_bit_idx    = bit_idx_q;
  assign o_fifo_pop   = bit_start && (phase_q == PH_START);
  assign o_frame_done = frame_end;

endmodule

// File: doc/uart_tx_frame_timer.md
# uart_tx_frame_timer

Parametrised UART transmit timing engine, the successor to the fixed-rate TX baud generator. It combines a runtime-programmable baud divisor with a frame sequencer. The sequencer covers 5–8 data bits, optional parity and 1 or 2 stop bits. It sits between the TX FIFO and the TX shift/serialiser logic. It tells the serialiser which bit of the frame to drive and when, and tells the FIFO when to pop.

## Interface
Parameters:
- DIV_W, 16, width of baud divisor and counter.
- DIV_RESET, 10416, divisor used when i_div is below DIV_MIN (50 MHz / 4800 baud).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_div  in  DIV_W  clocks per bit; sampled at frame acceptance.
- i_data_bits  in  2  data bit count: 0→5, 1→6, 2→7, 3→8; sampled at acceptance.
- i_parity_en  in  1  insert parity bit; sampled at acceptance.
- i_stop2  in  1  0 = 1 stop bit, 1 = 2 stop bits; sampled at acceptance.
- i_start  in  1  level request: FIFO non-empty and TX enabled.
- o_busy  out  1  frame in progress.
- o_bit_start  out  1  one-cycle pulse on the first clock of every bit.
- o_phase  out  3  current phase: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- o_bit_idx  out  3  data bit index (LSB first) in DATA; stop index 0/1 in STOP; else 0.
- o_fifo_pop  out  1  one-cycle pulse; the serialiser loads the word at this edge.
- o_frame_done  out  1  one-cycle pulse on the last clock of the final stop bit.

## Operation
- The FSM states equal the o_phase encoding.
- IDLE:
  - Counter is held at 0 and all pulses are low.
  - If i_start=1, the block latches i_div, i_data_bits, i_parity_en and i_stop2, then moves to START.
- Divisor rule: effective div = i_div when i_div ≥ 2 (DIV_MIN), else DIV_RESET. Config changes mid-frame have no effect.
- Bit timing:
  - The counter runs 0..div−1.
  - The end of a bit is the cycle where count == div−1.
  - The counter then wraps to 0.
- Transitions at end of bit:
  - START → DATA (idx 0).
  - DATA moves to idx+1 until idx == nbits−1, then goes to PARITY if enabled, else STOP (idx 0).
  - PARITY → STOP.
  - STOP idx 0 → STOP idx 1 if stop2, else the frame ends.
  - STOP idx 1 → frame end.
- Frame end:
  - If i_start=1 in that cycle, the block re-latches config and goes directly to START with no idle gap (back-to-back frames).
  - Otherwise it goes to IDLE.
- Frame length = (1 + nbits + parity_en + 1 + stop2) × div cycles.
- Pulse and status outputs:
  - o_bit_start is high when count == 0 and phase ≠ IDLE.
  - o_fifo_pop is high on the first cycle of START.
  - o_busy = (phase ≠ IDLE).
- All outputs are registered or decoded from registered state, with no combinational path from inputs.

## Timing
- Reset values: phase IDLE, counter 0, bit_idx 0, latched div = DIV_RESET, all outputs 0.
- Reset mid-frame aborts immediately to IDLE; no o_frame_done is issued.
- Latency: i_start rising in IDLE at edge N gives phase=START, o_bit_start=1 and o_fifo_pop=1 in cycle N+1.
- Consecutive o_bit_start pulses are exactly div cycles apart within a frame and across back-to-back frames.
- o_frame_done and the next frame's o_fifo_pop are in adjacent cycles when back-to-back.
- i_start deasserting mid-frame has no effect; it is only sampled in IDLE and at frame end.
- Counter width is DIV_W. div−1 must not underflow; the DIV_MIN clamp guarantees this.

## Structure
- Package uart_pkg holds:
  - phase enum/localparams (IDLE..STOP).
  - data-bit encoding table (0..3 → 5..8).
  - DIV_MIN = 2.
- Sub-module uart_baud_counter (DIV_W) contains the counter, wrap logic and the end-of-bit and bit-start strobes, with an enable input and a sync-clear input.
- uart_tx_frame_timer holds the FSM, config latches and output decode.

## Test plan
- DIV=4, 8N1, single i_start pulse:
  - o_fifo_pop at cycle 1.
  - 10 o_bit_start pulses spaced 4.
  - o_frame_done at cycle 40.
  - o_busy low at cycle 41.
- DIV=3, 5 data bits, parity, 2 stop, phase sequence: START, DATA0..4, PARITY, STOP0, STOP1, totalling 27 cycles.
- i_start held high, DIV=4, 8N1 for 3 frames:
  - o_fifo_pop exactly every 40 cycles.
  - No IDLE cycle between frames.
- i_div=0 and i_div=1: bit period equals DIV_RESET. Changing i_div mid-frame 4→8 keeps period 4 until the next frame.
- Reset asserted in DATA bit 3: all outputs 0 asynchronously. Release with i_start=1 gives a clean new frame from START.
- DIV=65535 (max): counter reaches 65534 and wraps without overflow, and the bit period is 65535.
